// File: rtl/clint_mh_if.sv
// AXI4-Lite bus bundle (32-bit address/data) shared by the CLINT slave and its masters.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip,
// registered mtip/msip lines, read/write AXI4-Lite register window.
module clint_mh #(
  parameter int unsigned NHART     = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  axi_lite_if.slave        s,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  localparam int unsigned   PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_NONE, REG_MSIP, REG_CMP_LO, REG_CMP_HI, REG_TIME_LO, REG_TIME_HI
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] hart;
  } reg_sel_t;

  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;

  function automatic reg_sel_t decode(input logic [31:0] addr);
    reg_sel_t    sel;
    logic [15:0] off;
    sel.kind = REG_NONE;
    sel.hart = '0;
    off      = addr[15:0];
    if (addr[31:16] == BASE_ADDR[31:16] && addr[1:0] == 2'b00) begin
      if (off < 16'h4000) begin
        if ({18'd0, off[15:2]} < NHART) begin
          sel.kind = REG_MSIP;
          sel.hart = off[4:2];
        end
      end else if (off < 16'h8000) begin
        if ({21'd0, off[13:3]} < NHART) begin
          sel.kind = off[2] ? REG_CMP_HI : REG_CMP_LO;
          sel.hart = off[5:3];
        end
      end else if (off == 16'hBFF8) begin
        sel.kind = REG_TIME_LO;
      end else if (off == 16'hBFFC) begin
        sel.kind = REG_TIME_HI;
      end
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // Architectural state
  logic [PW-1:0]    presc;
  logic [63:0]      mtime;
  logic [63:0]      mtimecmp [NHART];
  logic [NHART-1:0] msip_q;
  logic [NHART-1:0] mtip_q;
  logic             tick;

  // Read channel
  r_state_e    r_state, r_next;
  reg_sel_t    ar_sel;
  logic        ar_hs;
  logic [31:0] rd_val;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  // Write channel
  w_state_e    w_state, w_next;
  logic        aw_hs, w_hs, wr_commit;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  reg_sel_t    wr_sel;
  logic [1:0]  bresp_q;

  assign tick = (presc == PRESC_LAST);
  assign mtip = mtip_q;
  assign msip = msip_q;

  // ---------------- read path ----------------
  assign s.arready = (r_state == R_IDLE);
  assign s.rvalid  = (r_state == R_RESP);
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign ar_hs     = s.arvalid && s.arready;
  assign ar_sel    = decode(s.araddr);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values, which is what makes the read snapshot coherent.
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    // NOTE: defaults first; without them a path that skips an assignment
    // would infer a latch.
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s.arvalid) r_next = R_RESP;
      R_RESP:  if (s.rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (ar_sel.kind)
      REG_TIME_LO: rd_val = mtime[31:0];
      REG_TIME_HI: rd_val = mtime[63:32];
      default:     ;
    endcase
    for (int h = 0; h < NHART; h++) begin
      if (ar_sel.hart == 3'(h)) begin
        case (ar_sel.kind)
          REG_MSIP:   rd_val = {31'd0, msip_q[h]};
          REG_CMP_LO: rd_val = mtimecmp[h][31:0];
          REG_CMP_HI: rd_val = mtimecmp[h][63:32];
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= (ar_sel.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------- write path ----------------
  assign s.awready = (w_state == W_IDLE) || (w_state == W_HAVE_D);
  assign s.wready  = (w_state == W_IDLE) || (w_state == W_HAVE_A);
  assign s.bvalid  = (w_state == W_RESP);
  assign s.bresp   = bresp_q;
  assign aw_hs     = s.awvalid && s.awready;
  assign w_hs      = s.wvalid && s.wready;

  // Whichever half arrives second comes straight from the bus on the commit edge.
  assign wr_addr = (w_state == W_HAVE_A) ? aw_addr_q : s.awaddr;
  assign wr_data = (w_state == W_HAVE_D) ? w_data_q  : s.wdata;
  assign wr_strb = (w_state == W_HAVE_D) ? w_strb_q  : s.wstrb;
  assign wr_sel  = decode(wr_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    wr_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
          w_next    = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_A;
        end else if (w_hs) begin
          w_next = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs) begin
        wr_commit = 1'b1;
        w_next    = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        wr_commit = 1'b1;
        w_next    = W_RESP;
      end
      W_RESP:  if (s.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // NOTE: the AW/W holding registers are not reset: they are only consumed
  // after a handshake has loaded them, so a reset value would never be seen.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= s.awaddr;
    if (w_hs) begin
      w_data_q <= s.wdata;
      w_strb_q <= s.wstrb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       bresp_q <= RESP_OKAY;
    else if (wr_commit) bresp_q <= (wr_sel.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
  end

  // ---------------- timer and per-hart registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc  <= '0;
      mtime  <= '0;
      msip_q <= '0;
      mtip_q <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // A software write to either half wins over the tick and never carries.
      if (wr_commit && wr_sel.kind == REG_TIME_LO) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], wr_data, wr_strb);
      end else if (wr_commit && wr_sel.kind == REG_TIME_HI) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], wr_data, wr_strb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      for (int h = 0; h < NHART; h++) begin
        mtip_q[h] <= (mtime >= mtimecmp[h]);
        if (wr_commit && wr_sel.hart == 3'(h)) begin
          case (wr_sel.kind)
            REG_MSIP:   if (wr_strb[0]) msip_q[h] <= wr_data[0];
            REG_CMP_LO: mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], wr_data, wr_strb);
            REG_CMP_HI: mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wr_data, wr_strb);
            default:    ;
          endcase
        end
      end
    end
  end

endmodule
